// File: rtl/vram_fill_writer.sv
`default_nettype none
// ==========================================================================
// vram_fill_writer : rectangle fill engine, one VRAM pixel write per clock
// Revision: 1.0
// ==========================================================================
module vram_fill_writer #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x,
  input  logic [6:0]  req_y,
  input  logic [7:0]  req_w,
  input  logic [6:0]  req_h,
  input  logic [12:0] req_data,
  input  logic        abort,
  output logic        we,
  output logic [14:0] waddr,
  output logic [12:0] wdata,
  output logic        busy,
  output logic        done
);

  localparam logic [8:0]  C_FB_W_X = 9'(FB_W);
  localparam logic [7:0]  C_FB_H_Y = 8'(FB_H);
  localparam logic [16:0] C_STRIDE = 17'(FB_W);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x0_q, x0_d;
  logic [7:0]  w_q, w_d;
  logic [12:0] data_q, data_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [16:0] base_q, base_d;
  logic [7:0]  col_q, col_d;
  logic [6:0]  row_q, row_d;
  logic        we_q, we_d;
  logic [14:0] waddr_q, waddr_d;
  logic [12:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        emit;

  // Counters hold the pixels still to visit after the one currently on the outputs.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    w_d     = w_q;
    data_d  = data_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    emit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_w == 8'd0 || req_h == 7'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = FILL;
            x0_d    = req_x;
            w_d     = req_w;
            data_d  = req_data;
            x_d     = {1'b0, req_x};
            y_d     = {1'b0, req_y};
            // Only the origin row needs a product; later rows step by the stride.
            base_d  = {10'd0, req_y} * C_STRIDE;
            col_d   = req_w - 8'd1;
            row_d   = req_h - 7'd1;
            emit    = 1'b1;
          end
        end
      end
      FILL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (col_q == 8'd0 && row_q == 7'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (col_q != 8'd0) begin
            x_d   = x_q + 9'd1;
            col_d = col_q - 8'd1;
          end else begin
            x_d    = {1'b0, x0_q};
            col_d  = w_q - 8'd1;
            y_d    = y_q + 8'd1;
            base_d = base_q + C_STRIDE;
            row_d  = row_q - 7'd1;
          end
          emit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      we_d    = (x_d < C_FB_W_X) && (y_d < C_FB_H_Y);
      waddr_d = 15'(base_d + {8'd0, x_d});
      wdata_d = data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x0_q    <= 8'd0;
      w_q     <= 8'd0;
      data_q  <= 13'd0;
      x_q     <= 9'd0;
      y_q     <= 8'd0;
      base_q  <= 17'd0;
      col_q   <= 8'd0;
      row_q   <= 7'd0;
      we_q    <= 1'b0;
      waddr_q <= 15'd0;
      wdata_q <= 13'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      w_q     <= w_d;
      data_q  <= data_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == FILL);
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_fill_writer.sv
`default_nettype none
// Testbench for vram_fill_writer: table vectors, hand-written corner sequences
// and randomized fills checked against a nested-loop pixel model.
module tb_vram_fill_writer;

  localparam int FB_W = 160;
  localparam int FB_H = 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_x = 8'd0;
  logic [6:0]  req_y = 7'd0;
  logic [7:0]  req_w = 8'd0;
  logic [6:0]  req_h = 7'd0;
  logic [12:0] req_data = 13'd0;
  logic        abort = 1'b0;
  logic        we;
  logic [14:0] waddr;
  logic [12:0] wdata;
  logic        busy;
  logic        done;

  vram_fill_writer #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_data(req_data),
    .abort(abort), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [7:0]  w;
    logic [6:0]  h;
    logic [12:0] data;
    int          abort_at;
    int          exp_writes;
    int          exp_first;
    int          exp_last;
    bit          exp_done;
  } vec_t;

  // abort_at = k raises abort so it is sampled at the edge ending the k-th FILL cycle.
  task automatic run_fill(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                          input logic [6:0] h, input logic [12:0] data, input int abort_at,
                          output int nwr, output int first, output int last,
                          output bit got_done, output int model_wr);
    bit exp_we[$];
    int exp_addr[$];
    int n, lim;
    n = int'(w) * int'(h);
    for (int r = 0; r < int'(h); r++)
      for (int c = 0; c < int'(w); c++) begin
        exp_we.push_back((int'(x) + c < FB_W) && (int'(y) + r < FB_H));
        exp_addr.push_back((int'(y) + r) * FB_W + int'(x) + c);
      end
    lim = (abort_at > 0 && abort_at <= n) ? abort_at : n;
    model_wr = 0;
    for (int i = 0; i < lim; i++) if (exp_we[i]) model_wr++;
    nwr = 0; first = -1; last = -1; got_done = 1'b0;

    @(negedge clk);
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_x = x; req_y = y; req_w = w; req_h = h; req_data = data;
    @(negedge clk);
    req_valid = 1'b0;
    req_x = 8'($urandom); req_y = 7'($urandom); req_w = 8'($urandom);
    req_h = 7'($urandom); req_data = 13'($urandom);
    if (n == 0) begin
      chk("zero_busy", busy, 0);
      chk("zero_we", we, 0);
      chk("zero_done", done, 1);
      got_done = (done === 1'b1);
      @(negedge clk);
      chk("zero_done_once", done, 0);
      return;
    end
    for (int k = 1; k <= n; k++) begin
      chk("fill_busy", busy, 1);
      chk("fill_ready", req_ready, 0);
      chk("fill_done", done, 0);
      chk("fill_we", we, exp_we[k-1]);
      if (we === 1'b1) begin
        nwr++;
        if (first < 0) first = int'(waddr);
        last = int'(waddr);
      end
      if (exp_we[k-1]) begin
        chk("fill_waddr", waddr, exp_addr[k-1]);
        chk("fill_wdata", wdata, data);
      end
      if (k == abort_at) abort = 1'b1;
      @(negedge clk);
      if (k == abort_at) begin
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_we", we, 0);
        chk("abort_no_done", done, 0);
        @(negedge clk);
        chk("abort_no_done_later", done, 0);
        return;
      end
    end
    got_done = (done === 1'b1);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_we", we, 0);
    @(negedge clk);
    chk("done_once", done, 0);
  endtask

  vec_t vecs[11];

  initial begin
    int nwr, first, last, mwr;
    bit gd;

    vecs[0]  = '{8'd2,   7'd3,   8'd3,   7'd2,  13'h1FFF, 0, 6,   482,   644,   1'b1};
    vecs[1]  = '{8'd158, 7'd119, 8'd4,   7'd2,  13'h0AAA, 0, 2,   19198, 19199, 1'b1};
    vecs[2]  = '{8'd0,   7'd0,   8'd0,   7'd5,  13'h0123, 0, 0,   0,     0,     1'b1};
    vecs[3]  = '{8'd5,   7'd5,   8'd10,  7'd10, 13'h1555, 4, 4,   805,   808,   1'b0};
    vecs[4]  = '{8'd0,   7'd0,   8'd1,   7'd1,  13'h1234, 0, 1,   0,     0,     1'b1};
    vecs[5]  = '{8'd159, 7'd0,   8'd1,   7'd1,  13'h0F0F, 0, 1,   159,   159,   1'b1};
    vecs[6]  = '{8'd0,   7'd119, 8'd160, 7'd1,  13'h0001, 0, 160, 19040, 19199, 1'b1};
    vecs[7]  = '{8'd10,  7'd20,  8'd3,   7'd3,  13'h1E1E, 9, 9,   3210,  3532,  1'b0};
    vecs[8]  = '{8'd200, 7'd0,   8'd5,   7'd3,  13'h0777, 0, 0,   0,     0,     1'b1};
    vecs[9]  = '{8'd7,   7'd0,   8'd0,   7'd0,  13'h0002, 0, 0,   0,     0,     1'b1};
    vecs[10] = '{8'd100, 7'd100, 8'd8,   7'd30, 13'h1001, 0, 160, 16100, 19147, 1'b1};

    // Reset values must appear before any clock edge.
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_fill(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].data, vecs[i].abort_at,
               nwr, first, last, gd, mwr);
      chk($sformatf("vec%0d_writes", i), nwr, vecs[i].exp_writes);
      chk($sformatf("vec%0d_done", i), gd, vecs[i].exp_done);
      if (vecs[i].exp_writes > 0) begin
        chk($sformatf("vec%0d_first", i), first, vecs[i].exp_first);
        chk($sformatf("vec%0d_last", i), last, vecs[i].exp_last);
      end
    end

    // Abort while idle is ignored and a simultaneous request is still taken.
    @(negedge clk);
    req_valid = 1'b1; abort = 1'b1;
    req_x = 8'd1; req_y = 7'd1; req_w = 8'd1; req_h = 7'd1; req_data = 13'h0ABC;
    @(negedge clk);
    req_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 1);
    chk("idle_abort_we", we, 1);
    chk("idle_abort_waddr", waddr, 161);
    @(negedge clk);
    chk("idle_abort_done", done, 1);

    // Back-to-back: valid held high, second request taken in the done cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_x = 8'd0; req_y = 7'd0; req_w = 8'd2; req_h = 7'd1; req_data = 13'h0111;
    @(negedge clk);
    chk("b2b_a0_waddr", waddr, 0);
    req_x = 8'd4; req_y = 7'd2; req_w = 8'd1; req_h = 7'd1; req_data = 13'h0222;
    @(negedge clk);
    chk("b2b_a1_waddr", waddr, 1);
    chk("b2b_a1_wdata", wdata, 13'h0111);
    @(negedge clk);
    chk("b2b_done", done, 1);
    chk("b2b_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_b_we", we, 1);
    chk("b2b_b_waddr", waddr, 2 * FB_W + 4);
    chk("b2b_b_wdata", wdata, 13'h0222);
    @(negedge clk);
    chk("b2b_b_done", done, 1);
    @(negedge clk);

    // Asynchronous reset in the middle of a fill.
    req_valid = 1'b1;
    req_x = 8'd0; req_y = 7'd0; req_w = 8'd10; req_h = 7'd10; req_data = 13'h1357;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we", we, 0);
    chk("async_rst_ready", req_ready, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_waddr", waddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_done", done, 0);
    run_fill(8'd3, 7'd4, 8'd2, 7'd2, 13'h0C0C, 0, nwr, first, last, gd, mwr);
    chk("post_rst_writes", nwr, 4);
    chk("post_rst_first", first, 4 * FB_W + 3);
    chk("post_rst_last", last, 5 * FB_W + 4);

    // Randomized fills against the pixel model.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] rx, rw;
      logic [6:0] ry, rh;
      int ab;
      rx = 8'($urandom_range(0, 255));
      ry = 7'($urandom_range(0, 127));
      rw = 8'($urandom_range(0, 20));
      rh = 7'($urandom_range(0, 10));
      ab = 0;
      if (rw != 0 && rh != 0 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, int'(rw) * int'(rh));
      run_fill(rx, ry, rw, rh, 13'($urandom), ab, nwr, first, last, gd, mwr);
      chk("rand_writes", nwr, mwr);
      chk("rand_done", gd, (ab == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
